// File: rtl/shared_reg_rr_arbiter.sv
// shared_reg_rr_arbiter
//
// Round-robin arbiter in front of one shared data register. Each accepted
// request writes the register and records which requester wrote it. After
// every write a programmable cooldown blocks further grants for COOLDOWN
// cycles, so under continuous demand grants are COOLDOWN+1 cycles apart.
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous reset, active-high
//   req_vld     per-requester valid
//   req_data    packed requester data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_rd      one-hot grant, combinational from state, ptr and req_vld
//   dout        shared register value
//   dout_owner  index of the requester that last wrote dout
//   dout_vld    one-cycle pulse, dout was written on the previous edge
//   busy        high while the cooldown is running

module shared_reg_rr_arbiter #(
    parameter int                    N_REQ      = 4,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    COOLDOWN   = 2,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0,
    localparam int                   OW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_vld,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_rd,
    output logic [DATA_WIDTH-1:0]       dout,
    output logic [OW-1:0]               dout_owner,
    output logic                        dout_vld,
    output logic                        busy
);

    // The counter only ever holds COOLDOWN-1 down to 0.
    localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        COOL = 1'b1
    } state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [OW-1:0]           ptr;

    logic                    gnt_found;
    logic [OW-1:0]           gnt_idx;
    logic [OW-1:0]           ptr_next;
    logic [DATA_WIDTH-1:0]   gnt_data;
    int                      cand;

    // Rotating priority scan starting at ptr. The candidate index is wrapped
    // by subtraction rather than modulo so non-power-of-2 N_REQ works and no
    // divider is built. The grant is suppressed during reset so req_rd is
    // quiet while rst is high, even before any clock edge.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        req_rd    = '0;
        cand      = 0;
        if (!rst && state == IDLE) begin
            for (int k = 0; k < N_REQ; k++) begin
                cand = int'(ptr) + k;
                if (cand >= N_REQ) begin
                    cand = cand - N_REQ;
                end
                if (!gnt_found && req_vld[cand]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = OW'(cand);
                end
            end
        end
        if (gnt_found) begin
            req_rd[gnt_idx] = 1'b1;
        end
    end

    // Winner's data and the pointer value that puts the winner last in the
    // next scan.
    always_comb begin
        gnt_data = req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        if (gnt_idx == OW'(N_REQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = gnt_idx + 1'b1;
        end
    end

    // IDLE/COOL state machine. A write loads the register and, with a nonzero
    // cooldown, moves to COOL with cnt preset so that COOL lasts exactly
    // COOLDOWN cycles. busy is kept as its own flop alongside state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            ptr        <= '0;
            dout       <= INIT_VAL;
            dout_owner <= '0;
            dout_vld   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        dout       <= gnt_data;
                        dout_owner <= gnt_idx;
                        dout_vld   <= 1'b1;
                        ptr        <= ptr_next;
                        if (COOLDOWN > 0) begin
                            state <= COOL;
                            busy  <= 1'b1;
                            cnt   <= CW'(COOLDOWN - 1);
                        end
                    end else begin
                        dout_vld <= 1'b0;
                    end
                end
                COOL: begin
                    dout_vld <= 1'b0;
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_reg_rr_arbiter.sv
// tb_shared_reg_rr_arbiter
//
// Three arbiter instances share clock and reset:
//   unit 0: N_REQ=4, COOLDOWN=2, INIT_VAL=0xC3
//   unit 1: N_REQ=4, COOLDOWN=0
//   unit 2: N_REQ=3, COOLDOWN=2
// A reference model per unit tracks the rotating pointer, the number of
// blocked cycles left and the expected register contents, and every cycle
// is compared against it. Directed sequences add explicit expectations.

module tb_shared_reg_rr_arbiter;

    localparam int NR[3]    = '{4, 4, 3};
    localparam int CDN[3]   = '{2, 0, 2};
    localparam int INITV[3] = '{'hC3, 0, 0};

    logic       clk;
    logic       rst;
    logic [3:0] vld [3];
    logic [7:0] dat [3][4];
    logic [31:0] flat [3];

    logic [3:0] rd [3];
    logic [2:0] rdC;
    logic [7:0] dout [3];
    logic [1:0] own [3];
    logic       dv [3];
    logic       busy [3];

    int checks = 0;
    int errors = 0;

    // Reference model state
    int       mptr [3];
    int       mblk [3];
    int       mdout [3];
    int       mown [3];
    int       mvld [3];
    int       lastG [3];
    logic [3:0] obsRd [3];

    always_comb begin
        for (int u = 0; u < 3; u++) begin
            flat[u] = {dat[u][3], dat[u][2], dat[u][1], dat[u][0]};
        end
    end

    assign rd[2] = {1'b0, rdC};

    shared_reg_rr_arbiter #(.N_REQ(4), .DATA_WIDTH(8), .COOLDOWN(2), .INIT_VAL(8'hC3)) u0 (
        .clk(clk), .rst(rst), .req_vld(vld[0]), .req_data(flat[0]),
        .req_rd(rd[0]), .dout(dout[0]), .dout_owner(own[0]), .dout_vld(dv[0]), .busy(busy[0])
    );

    shared_reg_rr_arbiter #(.N_REQ(4), .DATA_WIDTH(8), .COOLDOWN(0), .INIT_VAL(8'h00)) u1 (
        .clk(clk), .rst(rst), .req_vld(vld[1]), .req_data(flat[1]),
        .req_rd(rd[1]), .dout(dout[1]), .dout_owner(own[1]), .dout_vld(dv[1]), .busy(busy[1])
    );

    shared_reg_rr_arbiter #(.N_REQ(3), .DATA_WIDTH(8), .COOLDOWN(2), .INIT_VAL(8'h00)) u2 (
        .clk(clk), .rst(rst), .req_vld(vld[2][2:0]), .req_data(flat[2][23:0]),
        .req_rd(rdC), .dout(dout[2]), .dout_owner(own[2]), .dout_vld(dv[2]), .busy(busy[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int modelGrant(input int u);
        if (mblk[u] > 0) return -1;
        for (int k = 0; k < NR[u]; k++) begin
            int i = (mptr[u] + k) % NR[u];
            if (vld[u][i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] oneHot(input int g);
        logic [3:0] r = 4'b0000;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic modelReset();
        for (int u = 0; u < 3; u++) begin
            mptr[u]  = 0;
            mblk[u]  = 0;
            mdout[u] = INITV[u];
            mown[u]  = 0;
            mvld[u]  = 0;
            lastG[u] = -1;
        end
    endtask

    task automatic clearInputs();
        for (int u = 0; u < 3; u++) begin
            vld[u] = 4'b0000;
            for (int j = 0; j < 4; j++) dat[u][j] = 8'h00;
        end
    endtask

    // One clock cycle: called 1 time unit after a rising edge. Checks the
    // combinational grant mid-cycle, then the registered outputs 1 unit
    // after the next rising edge.
    task automatic stepCycle();
        int g [3];
        #3;
        for (int u = 0; u < 3; u++) begin
            g[u] = modelGrant(u);
            obsRd[u] = rd[u];
            checkOutput($sformatf("req_rd[u%0d]", u), {28'd0, rd[u]}, {28'd0, oneHot(g[u])});
        end
        @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            if (g[u] >= 0) begin
                mdout[u] = dat[u][g[u]];
                mown[u]  = g[u];
                mvld[u]  = 1;
                mptr[u]  = (g[u] + 1) % NR[u];
                mblk[u]  = CDN[u];
            end else begin
                mvld[u] = 0;
                if (mblk[u] > 0) mblk[u]--;
            end
            lastG[u] = g[u];
            checkOutput($sformatf("dout[u%0d]", u), {24'd0, dout[u]}, mdout[u]);
            checkOutput($sformatf("owner[u%0d]", u), {30'd0, own[u]}, mown[u]);
            checkOutput($sformatf("dout_vld[u%0d]", u), {31'd0, dv[u]}, mvld[u]);
            checkOutput($sformatf("busy[u%0d]", u), {31'd0, busy[u]}, (mblk[u] > 0) ? 1 : 0);
        end
    endtask

    // Random requesters: a served requester drops its request; an idle one
    // raises a new request with fresh data now and then. Pending requests
    // keep valid and data stable until they are served.
    task automatic applyStimulus();
        for (int u = 0; u < 3; u++) begin
            if (lastG[u] >= 0) vld[u][lastG[u]] = 1'b0;
            for (int j = 0; j < NR[u]; j++) begin
                if (!vld[u][j] && $urandom_range(0, 2) == 0) begin
                    vld[u][j] = 1'b1;
                    dat[u][j] = 8'($urandom);
                end
            end
        end
    endtask

    int ownA [16];
    int ownB [16];
    int ownC [16];
    int nA, nB, nC;

    initial begin
        rst = 1'b1;
        clearInputs();
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_dout", {24'd0, dout[0]}, 32'hC3);
        checkOutput("reset_busy", {31'd0, busy[0]}, 0);
        checkOutput("reset_rd", {28'd0, rd[0]}, 0);
        rst = 1'b0;

        // Asynchronous reset while cooling down
        vld[0] = 4'b0001;
        dat[0][0] = 8'h77;
        stepCycle();
        checkOutput("t1_busy_before", {31'd0, busy[0]}, 1);
        vld[0] = 4'b0000;
        #2;
        vld[0] = 4'b1000;
        rst = 1'b1;
        #1;
        checkOutput("t1_dout", {24'd0, dout[0]}, 32'hC3);
        checkOutput("t1_busy", {31'd0, busy[0]}, 0);
        checkOutput("t1_rd", {28'd0, rd[0]}, 0);
        checkOutput("t1_vld", {31'd0, dv[0]}, 0);
        checkOutput("t1_owner", {30'd0, own[0]}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        vld[0] = 4'b0000;
        modelReset();

        // Single request from requester 2, then pointer at 3 favours 0 over 1
        vld[0] = 4'b0100;
        dat[0][2] = 8'h5A;
        stepCycle();
        checkOutput("t2_rd", {28'd0, obsRd[0]}, 4'b0100);
        checkOutput("t2_dout", {24'd0, dout[0]}, 32'h5A);
        checkOutput("t2_owner", {30'd0, own[0]}, 2);
        checkOutput("t2_vld", {31'd0, dv[0]}, 1);
        checkOutput("t2_busy1", {31'd0, busy[0]}, 1);
        vld[0] = 4'b0011;
        dat[0][0] = 8'hA0;
        dat[0][1] = 8'hA1;
        stepCycle();
        checkOutput("t2_gap1_rd", {28'd0, obsRd[0]}, 0);
        checkOutput("t2_busy2", {31'd0, busy[0]}, 1);
        checkOutput("t2_vld_drop", {31'd0, dv[0]}, 0);
        stepCycle();
        checkOutput("t2_gap2_rd", {28'd0, obsRd[0]}, 0);
        checkOutput("t2_busy_end", {31'd0, busy[0]}, 0);
        stepCycle();
        checkOutput("t4_first_rd", {28'd0, obsRd[0]}, 4'b0001);
        checkOutput("t4_first_dout", {24'd0, dout[0]}, 32'hA0);
        vld[0] = 4'b0010;
        stepCycle();
        stepCycle();
        stepCycle();
        checkOutput("t4_second_rd", {28'd0, obsRd[0]}, 4'b0010);
        checkOutput("t4_second_owner", {30'd0, own[0]}, 1);
        vld[0] = 4'b0000;

        // Continuous demand on all three units from a fresh reset
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        vld[0] = 4'b1111;
        for (int j = 0; j < 4; j++) dat[0][j] = 8'(8'h10 + j);
        vld[1] = 4'b1010;
        dat[1][1] = 8'h21;
        dat[1][3] = 8'h23;
        vld[2] = 4'b0111;
        for (int j = 0; j < 3; j++) dat[2][j] = 8'(8'h30 + j);
        nA = 0;
        nB = 0;
        nC = 0;
        for (int c = 0; c < 13; c++) begin
            stepCycle();
            if (dv[0] && nA < 16) begin ownA[nA] = int'(own[0]); nA++; end
            if (dv[1] && nB < 16) begin ownB[nB] = int'(own[1]); nB++; end
            if (dv[2] && nC < 16) begin ownC[nC] = int'(own[2]); nC++; end
            checkOutput("t5_busy", {31'd0, busy[1]}, 0);
        end
        checkOutput("t3_count", nA, 5);
        checkOutput("t3_own0", ownA[0], 0);
        checkOutput("t3_own1", ownA[1], 1);
        checkOutput("t3_own2", ownA[2], 2);
        checkOutput("t3_own3", ownA[3], 3);
        checkOutput("t3_own4", ownA[4], 0);
        checkOutput("t5_count", nB, 13);
        checkOutput("t5_own0", ownB[0], 1);
        checkOutput("t5_own1", ownB[1], 3);
        checkOutput("t5_own2", ownB[2], 1);
        checkOutput("t6_count", nC, 5);
        checkOutput("t6_own0", ownC[0], 0);
        checkOutput("t6_own1", ownC[1], 1);
        checkOutput("t6_own2", ownC[2], 2);
        checkOutput("t6_own3", ownC[3], 0);

        // Random traffic against the model
        clearInputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        for (int c = 0; c < 400; c++) begin
            applyStimulus();
            stepCycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
